// File: rtl/fsm_6s2i_seq_driver.sv
// Walks a 6-state/2-input Moore FSM to a requested state along the shortest in_ path, shadowing its state.
// Latency: k+1 cycles from acceptance to done_val for a k-step path; error targets (6,7) complete in 1 cycle.
// Backpressure: req_rdy only in IDLE; optional FSM_6S2I_SEQ_DRIVER_CHECK_EN adds dut_state/mismatch.
module fsm_6s2i_seq_driver #(
  parameter logic [1:0] IDLE_IN = 2'b10,
  parameter int         STEP_W  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_val,
  output logic              req_rdy,
  input  logic [2:0]        req_target,
  output logic [1:0]        in_,
  output logic [2:0]        exp_state,
  output logic [1:0]        exp_out,
  output logic              done_val,
  output logic              done_err,
`ifdef FSM_6S2I_SEQ_DRIVER_CHECK_EN
  output logic [STEP_W-1:0] done_steps,
  input  logic [2:0]        dut_state,
  output logic              mismatch
`else
  output logic [STEP_W-1:0] done_steps
`endif
);

  localparam logic [2:0] ST_A = 3'd0;
  localparam logic [2:0] ST_B = 3'd1;
  localparam logic [2:0] ST_C = 3'd2;
  localparam logic [2:0] ST_D = 3'd3;
  localparam logic [2:0] ST_E = 3'd4;
  localparam logic [2:0] ST_F = 3'd5;

  typedef enum logic {IDLE, DRIVE} drv_t;

  drv_t              drv_q, drv_d;
  logic [2:0]        target_q;
  logic [2:0]        shadow_q;
  logic [STEP_W-1:0] count_q;
  logic              count_clr;
  logic              count_inc;

  // Row packed as next state for in_ = 11,10,01,00 (MSB first).
  function automatic logic [2:0] fsm_next(input logic [2:0] s, input logic [1:0] i);
    logic [11:0] row;
    case (s)
      ST_A:    row = {ST_E, ST_A, ST_B, ST_A};
      ST_B:    row = {ST_E, ST_A, ST_B, ST_C};
      ST_C:    row = {ST_E, ST_A, ST_D, ST_A};
      ST_D:    row = {ST_E, ST_A, ST_B, ST_C};
      ST_E:    row = {ST_E, ST_A, ST_F, ST_F};
      default: row = {ST_A, ST_A, ST_A, ST_A};
    endcase
    case (i)
      2'b00:   fsm_next = row[2:0];
      2'b01:   fsm_next = row[5:3];
      2'b10:   fsm_next = row[8:6];
      default: fsm_next = row[11:9];
    endcase
  endfunction

  // Row packed as first hop toward target F,E,D,C,B,A; the diagonal entry is never used.
  function automatic logic [1:0] hop(input logic [2:0] s, input logic [2:0] t);
    logic [11:0] row;
    case (s)
      ST_A:    row = {2'b11, 2'b11, 2'b01, 2'b01, 2'b01, IDLE_IN};
      ST_B:    row = {2'b11, 2'b11, 2'b00, 2'b00, IDLE_IN, 2'b10};
      ST_C:    row = {2'b11, 2'b11, 2'b01, IDLE_IN, 2'b00, 2'b00};
      ST_D:    row = {2'b11, 2'b11, IDLE_IN, 2'b00, 2'b01, 2'b10};
      ST_E:    row = {2'b00, IDLE_IN, 2'b10, 2'b10, 2'b10, 2'b10};
      default: row = {IDLE_IN, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    endcase
    case (t)
      ST_A:    hop = row[1:0];
      ST_B:    hop = row[3:2];
      ST_C:    hop = row[5:4];
      ST_D:    hop = row[7:6];
      ST_E:    hop = row[9:8];
      default: hop = row[11:10];
    endcase
  endfunction

  always_comb begin
    drv_d      = drv_q;
    req_rdy    = 1'b0;
    in_        = IDLE_IN;
    done_val   = 1'b0;
    done_err   = 1'b0;
    done_steps = '0;
    count_clr  = 1'b0;
    count_inc  = 1'b0;
    case (drv_q)
      IDLE: begin
        req_rdy = 1'b1;
        if (req_val) begin
          drv_d     = DRIVE;
          count_clr = 1'b1;
        end
      end
      DRIVE: begin
        if (target_q > ST_F) begin
          done_val   = 1'b1;
          done_err   = 1'b1;
          done_steps = count_q;
          drv_d      = IDLE;
        end else if (shadow_q == target_q) begin
          done_val   = 1'b1;
          done_steps = count_q;
          drv_d      = IDLE;
        end else begin
          in_       = hop(shadow_q, target_q);
          count_inc = 1'b1;
        end
      end
      default: drv_d = IDLE;
    endcase
  end

  // Shadow advances every edge, so an idle edge always lands it in A before a walk starts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drv_q    <= IDLE;
      target_q <= ST_A;
      shadow_q <= ST_A;
      count_q  <= '0;
    end else begin
      drv_q    <= drv_d;
      shadow_q <= fsm_next(shadow_q, in_);
      if (count_clr) begin
        count_q  <= '0;
        target_q <= req_target;
      end else if (count_inc) begin
        count_q <= count_q + STEP_W'(1);
      end
    end
  end

  assign exp_state = shadow_q;

  always_comb begin
    case (shadow_q)
      ST_D:       exp_out = 2'b01;
      ST_E, ST_F: exp_out = 2'b10;
      default:    exp_out = 2'b00;
    endcase
  end

`ifdef FSM_6S2I_SEQ_DRIVER_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mismatch <= 1'b0;
    end else if (dut_state != shadow_q) begin
      mismatch <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fsm_6s2i_seq_driver.sv
// Directed bench for fsm_6s2i_seq_driver: table of target requests plus reset and check-port sequences.
module tb_fsm_6s2i_seq_driver;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       req_val = 1'b0;
  logic       req_rdy;
  logic [2:0] req_target = 3'd0;
  logic [1:0] in_;
  logic [2:0] exp_state;
  logic [1:0] exp_out;
  logic       done_val;
  logic       done_err;
  logic [2:0] done_steps;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

`ifdef FSM_6S2I_SEQ_DRIVER_CHECK_EN
  logic [2:0] dut_state;
  logic       mismatch;
  logic [2:0] model_state;
  logic       force_c = 1'b0;

  function automatic logic [2:0] model_next(input logic [2:0] s, input logic [1:0] i);
    case (s)
      3'd0: model_next = (i == 2'b01) ? 3'd1 : (i == 2'b11) ? 3'd4 : 3'd0;
      3'd1: model_next = (i == 2'b00) ? 3'd2 : (i == 2'b01) ? 3'd1 : (i == 2'b10) ? 3'd0 : 3'd4;
      3'd2: model_next = (i == 2'b01) ? 3'd3 : (i == 2'b11) ? 3'd4 : 3'd0;
      3'd3: model_next = (i == 2'b00) ? 3'd2 : (i == 2'b01) ? 3'd1 : (i == 2'b10) ? 3'd0 : 3'd4;
      3'd4: model_next = (i == 2'b10) ? 3'd0 : (i == 2'b11) ? 3'd4 : 3'd5;
      default: model_next = 3'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_state <= 3'd0;
    else          model_state <= model_next(model_state, in_);
  end

  assign dut_state = force_c ? 3'd2 : model_state;

  fsm_6s2i_seq_driver dut (
    .clk(clk), .reset_n(reset_n), .req_val(req_val), .req_rdy(req_rdy),
    .req_target(req_target), .in_(in_), .exp_state(exp_state), .exp_out(exp_out),
    .done_val(done_val), .done_err(done_err), .done_steps(done_steps),
    .dut_state(dut_state), .mismatch(mismatch)
  );
`else
  fsm_6s2i_seq_driver dut (
    .clk(clk), .reset_n(reset_n), .req_val(req_val), .req_rdy(req_rdy),
    .req_target(req_target), .in_(in_), .exp_state(exp_state), .exp_out(exp_out),
    .done_val(done_val), .done_err(done_err), .done_steps(done_steps)
  );
`endif

  typedef struct {
    logic [2:0] target;
    logic [7:0] seq;     // hops packed first hop in [1:0]
    int         nhops;
    logic       err;
    logic [2:0] fstate;
    logic [1:0] fout;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Issues one request at a negedge and returns at the negedge of the done cycle (or on timeout).
  task automatic do_req(input logic [2:0] tgt, output logic [7:0] seq, output int nhops,
                        output logic got_done);
    seq = 8'h00;
    nhops = 0;
    got_done = 1'b0;
    check("req_rdy_before_accept", req_rdy, 1);
    req_val = 1'b1;
    req_target = tgt;
    @(posedge clk);
    @(negedge clk);
    req_val = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (done_val) begin
        got_done = 1'b1;
        break;
      end
      if (nhops < 4) seq[nhops*2 +: 2] = in_;
      nhops++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] seq;
    int         nhops;
    logic       got_done;
    int         stray;

    // After the idle acceptance edge the shadow is always A, so every walk starts from A.
    vecs[0] = '{3'd0, 8'h00,            0, 1'b0, 3'd0, 2'b00};
    vecs[1] = '{3'd1, 8'h01,            1, 1'b0, 3'd1, 2'b00};
    vecs[2] = '{3'd2, 8'h01,            2, 1'b0, 3'd2, 2'b00};
    vecs[3] = '{3'd3, {2'b01,2'b00,2'b01} , 3, 1'b0, 3'd3, 2'b01};
    vecs[4] = '{3'd4, 8'h03,            1, 1'b0, 3'd4, 2'b10};
    vecs[5] = '{3'd5, {2'b00,2'b11},    2, 1'b0, 3'd5, 2'b10};
    vecs[6] = '{3'd3, {2'b01,2'b00,2'b01} , 3, 1'b0, 3'd3, 2'b01};
    vecs[7] = '{3'd7, 8'h00,            0, 1'b1, 3'd0, 2'b00};

    #1 reset_n = 1'b0;
    #2;
    check("rst_in", in_, 2'b10);
    check("rst_exp_state", exp_state, 0);
    check("rst_req_rdy", req_rdy, 1);
    check("rst_done_val", done_val, 0);
    check("rst_done_err", done_err, 0);
    check("rst_done_steps", done_steps, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_in", in_, 2'b10);
    check("idle_exp_state", exp_state, 0);
    check("idle_req_rdy", req_rdy, 1);
    check("idle_done_val", done_val, 0);

    // Vector 5 (F) is followed by vector 6 (D), exercising the F->A idle edge.
    for (int v = 0; v < 8; v++) begin
      do_req(vecs[v].target, seq, nhops, got_done);
      check("done_seen", got_done, 1);
      check("hop_count", nhops, vecs[v].nhops);
      check("hop_seq", seq, vecs[v].seq);
      check("done_steps", done_steps, vecs[v].nhops);
      check("done_err", done_err, vecs[v].err);
      check("done_exp_state", exp_state, vecs[v].fstate);
      check("done_exp_out", exp_out, vecs[v].fout);
      check("done_in_idle", in_, 2'b10);
      check("done_req_rdy", req_rdy, 0);
      @(negedge clk);
      check("after_done_val", done_val, 0);
      check("after_req_rdy", req_rdy, 1);
      check("after_exp_state", exp_state, 0);
    end

    // Reset mid-walk toward D: must drop the request silently.
    req_val = 1'b1;
    req_target = 3'd3;
    @(posedge clk);
    @(negedge clk);
    req_val = 1'b0;
    check("midwalk_first_hop", in_, 2'b01);
    @(negedge clk);
    check("midwalk_exp_state", exp_state, 1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_exp_state", exp_state, 0);
    check("midrst_req_rdy", req_rdy, 1);
    check("midrst_in", in_, 2'b10);
    check("midrst_done_val", done_val, 0);
    @(negedge clk);
    reset_n = 1'b1;
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_val) stray++;
    end
    check("midrst_no_done", stray, 0);
    check("midrst_idle_rdy", req_rdy, 1);

`ifdef FSM_6S2I_SEQ_DRIVER_CHECK_EN
    check("mm_clear", mismatch, 0);
    do_req(3'd1, seq, nhops, got_done);
    check("mm_reach_b", exp_state, 1);
    check("mm_still_clear", mismatch, 0);
    force_c = 1'b1;
    @(negedge clk);
    force_c = 1'b0;
    check("mm_set", mismatch, 1);
    repeat (3) @(negedge clk);
    check("mm_sticky", mismatch, 1);
    reset_n = 1'b0;
    #1;
    check("mm_reset", mismatch, 0);
    @(negedge clk);
    reset_n = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fsm_6s2i_seq_driver.md
Name: fsm_6s2i_seq_driver

Overview:
- Stimulus-side partner for the 6-state, 2-input Moore FSM block: accepts "go to state X" requests over a val/rdy handshake and drives the FSM's 2-bit in_ along the shortest path to X.
- Keeps a shadow copy of the FSM state and expected Moore output, and reports completion with a step count.
- Used in directed/random traffic generators and as a bring-up driver in front of the FSM.

Parameters:
- IDLE_IN, 2'b10, in_ value driven whenever no path is being walked; moves every state to A and holds A.
- STEP_W, 3, width of done_steps; the longest path is 4 steps.

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- req_val  in  1  target request valid
- req_rdy  out  1  driver can accept a request
- req_target  in  3  target state code (A=0,B=1,C=2,D=3,E=4,F=5)
- in_  out  2  input to the FSM, sampled by the FSM on the same edge as the shadow
- exp_state  out  3  shadow FSM state
- exp_out  out  2  expected FSM Moore output for exp_state
- done_val  out  1  one-cycle completion pulse
- done_err  out  1  qualifies done_val: target code was 6 or 7
- done_steps  out  STEP_W  number of in_ values driven for this request

Behaviour:
- Shadow FSM transitions, listed as in_ 00/01/10/11 -> next state:
  - A: A/B/A/E
  - B: C/B/A/E
  - C: A/D/A/E
  - D: C/B/A/E
  - E: F/F/A/E
  - F: A/A/A/A
- exp_out: A=00, B=00, C=00, D=01, E=10, F=10.
- The shadow updates every edge, including idle cycles: exp_state <= next(exp_state, in_).
- Driver FSM has two states, IDLE and DRIVE.
  - IDLE: req_rdy=1, in_=IDLE_IN. On req_val&&req_rdy, capture the target, clear the step counter, and go to DRIVE.
  - DRIVE: req_rdy=0.
    - If exp_state==target: done_val=1, done_steps=count, in_=IDLE_IN, next state IDLE.
    - Otherwise: in_=hop(exp_state,target) and count+1.
- All DRIVE-state outputs are combinational from registers only; there is no in-to-out path from req_* to in_.
- Hop table (row = current state, entries = in_ for target A,B,C,D,E,F; "-" means already at target):
  - A: -,01,01,01,11,11
  - B: 10,-,00,00,11,11
  - C: 00,00,01,01,11,11
  - D: 10,01,00,00,11,11
  - E: 10,10,10,10,-,00
  - F: 00,00,00,00,00,-
- The table is the shortest path; ties go to the lowest in_ code.
- Latency: the request is accepted at edge N. The first hop is driven in the cycle after edge N, computed from the shadow state that already advanced under IDLE_IN. done_val rises k cycles after acceptance for a k-step path (k=0..4).
- Target equal to the post-acceptance shadow: done_val in the first DRIVE cycle with steps=0.
- Target 6 or 7: no path is walked. done_val=1 and done_err=1 in the first DRIVE cycle, steps=0, in_=IDLE_IN.
- Back-to-back requests: req_rdy rises the cycle after done_val, and a new request is never accepted in the done cycle.
- Reset (reset_n low, any time including mid-walk), applied asynchronously:
  - driver goes to IDLE; exp_state=A; count=0
  - done_val=0, done_err=0, done_steps=0
  - req_rdy=1, in_=IDLE_IN
  - any in-flight request is dropped without a done pulse.

Optional Feature:
- Macro FSM_6S2I_SEQ_DRIVER_CHECK_EN.
- When defined, adds two ports:
  - dut_state, input, 3 bits: the observed FSM state.
  - mismatch, output, 1 bit: sticky flag, set on the first edge where dut_state != exp_state; cleared only by reset_n.
- Without the macro, neither port exists and there is no comparison logic.
- Behaviour of all other ports is identical with or without the macro.

Test Plan:
- Release reset; idle 3 cycles -> in_=10, exp_state=A, req_rdy=1, done_val=0.
- From A, request D -> in_ sequence 01,00,01; then done_val=1, steps=3, exp_state=D, exp_out=01.
- From A, request F -> in_ 11,00; done steps=2, exp_out=10. Then request D -> the F->A idle edge, then 01,00,01, steps=3.
- From A, request A -> done_val in first DRIVE cycle, steps=0. Request 7 -> done_val=1, done_err=1, steps=0, exp_state unchanged at A.
- Assert reset_n low mid-walk toward D (after in_=01) -> immediately exp_state=A, req_rdy=1, in_=10, and no done_val follows.
- With CHECK_EN, force dut_state=C while exp_state=B -> mismatch=1, which stays set until reset_n.
